watch_alarm: RTL and testbench

Alarm controller that sits directly downstream of the `watch` time counter and consumes its `seconds`/`minutes`/`hours` outputs. It holds a programmable alarm time and raises `alarm_out` when the watch reaches that time. It supports snooze with hour/day wrap, a manual stop, and an automatic ring timeout. It runs on the same clock as `watch` and drives the buzzer/indicator stage.

---
 rtl/watch_alarm.sv | 151 +++++++++++++++
 tb/tb_watch_alarm.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_alarm.sv
// Alarm controller fed by the watch time counter: holds an alarm time, rings on match,
// and supports snooze (with hour/day wrap), manual stop and an automatic ring timeout.
module watch_alarm #(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_LIMIT_SEC = 60
) (
    input  logic       Clk_5sec,
    input  logic       reset,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    input  logic       arm,
    input  logic       set_en,
    input  logic [4:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic       snooze,
    input  logic       stop,
    output logic       alarm_out,
    output logic       armed,
    output logic       snoozing,
    output logic       set_err,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_RINGING = 2'd2,
        S_SNOOZE  = 2'd3
    } state_t;

    localparam logic [7:0] RING_LAST = 8'(RING_LIMIT_SEC - 1);
    localparam logic [6:0] SNZ_ADD   = 7'(SNOOZE_MIN);

    // Handshake note: there is no valid/ready pairing here; every input is a level
    // sampled on each rising edge and every output is a register updated on that edge.

    state_t      state;
    state_t      state_nxt;
    logic [16:0] prev_time;
    logic [4:0]  snz_hours;
    logic [4:0]  snz_hours_nxt;
    logic [5:0]  snz_minutes;
    logic [5:0]  snz_minutes_nxt;
    logic [7:0]  ring_cnt;
    logic [7:0]  ring_cnt_nxt;

    logic        new_time;
    logic        on_minute;
    logic        alarm_match;
    logic        snooze_match;
    logic [6:0]  snz_sum;
    logic [6:0]  snz_wrap;
    logic        snz_carry;
    logic [5:0]  snz_min_calc;
    logic [4:0]  snz_hr_calc;
    logic        set_ok_state;
    logic        set_bad;

    assign new_time     = {hours, minutes, seconds} != prev_time;
    assign on_minute    = new_time && (seconds == 6'd0);
    assign alarm_match  = on_minute && (hours == alarm_hours) && (minutes == alarm_minutes);
    assign snooze_match = on_minute && (hours == snz_hours) && (minutes == snz_minutes);

    // Snooze target: minutes wrap mod 60, a single carry bumps the hour mod 24.
    assign snz_sum      = {1'b0, minutes} + SNZ_ADD;
    assign snz_carry    = snz_sum >= 7'd60;
    assign snz_wrap     = snz_sum - 7'd60;
    assign snz_min_calc = snz_carry ? snz_wrap[5:0] : snz_sum[5:0];
    assign snz_hr_calc  = !snz_carry ? hours : ((hours == 5'd23) ? 5'd0 : hours + 5'd1);

    assign set_ok_state = (state == S_IDLE) || (state == S_ARMED);
    assign set_bad      = (set_hours > 5'd23) || (set_minutes > 6'd59);

    always_comb begin
        state_nxt       = state;
        ring_cnt_nxt    = ring_cnt;
        snz_hours_nxt   = snz_hours;
        snz_minutes_nxt = snz_minutes;
        if (!arm) begin
            state_nxt    = S_IDLE;
            ring_cnt_nxt = 8'd0;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_ARMED;
                S_ARMED: begin
                    if (alarm_match) begin
                        state_nxt    = S_RINGING;
                        ring_cnt_nxt = 8'd0;
                    end
                end
                S_RINGING: begin
                    if (stop) begin
                        state_nxt = S_ARMED;
                    end else if (snooze) begin
                        state_nxt       = S_SNOOZE;
                        snz_hours_nxt   = snz_hr_calc;
                        snz_minutes_nxt = snz_min_calc;
                    end else if (new_time) begin
                        ring_cnt_nxt = ring_cnt + 8'd1;
                        if (ring_cnt == RING_LAST) begin
                            state_nxt = S_ARMED;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (stop) begin
                        state_nxt = S_ARMED;
                    end else if (snooze_match) begin
                        state_nxt    = S_RINGING;
                        ring_cnt_nxt = 8'd0;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk_5sec or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            prev_time     <= 17'd0;
            snz_hours     <= 5'd0;
            snz_minutes   <= 6'd0;
            ring_cnt      <= 8'd0;
            alarm_hours   <= 5'd0;
            alarm_minutes <= 6'd0;
            alarm_out     <= 1'b0;
            armed         <= 1'b0;
            snoozing      <= 1'b0;
            set_err       <= 1'b0;
        end else begin
            state       <= state_nxt;
            prev_time   <= {hours, minutes, seconds};
            snz_hours   <= snz_hours_nxt;
            snz_minutes <= snz_minutes_nxt;
            ring_cnt    <= ring_cnt_nxt;
            alarm_out   <= state_nxt == S_RINGING;
            armed       <= state_nxt != S_IDLE;
            snoozing    <= state_nxt == S_SNOOZE;
            set_err     <= set_en && set_ok_state && set_bad;
            // Match above used the old alarm value; a new one applies from the next edge.
            if (set_en && set_ok_state && !set_bad) begin
                alarm_hours   <= set_hours;
                alarm_minutes <= set_minutes;
            end
        end
    end

endmodule

// File: tb/tb_watch_alarm.sv
// Bench for watch_alarm: directed scenarios plus random time/control traffic,
// checked every cycle against a time-of-day based reference model.
module tb_watch_alarm;

    localparam int SNZ = 5;
    localparam int LIM = 60;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] seconds = '0;
    logic [5:0] minutes = '0;
    logic [4:0] hours = '0;
    logic       arm = 1'b0;
    logic       set_en = 1'b0;
    logic [4:0] set_hours = '0;
    logic [5:0] set_minutes = '0;
    logic       snooze = 1'b0;
    logic       stop = 1'b0;
    logic       alarm_out;
    logic       armed;
    logic       snoozing;
    logic       set_err;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;

    watch_alarm #(.SNOOZE_MIN(SNZ), .RING_LIMIT_SEC(LIM)) dut (
        .Clk_5sec(clk), .reset(reset), .seconds(seconds), .minutes(minutes),
        .hours(hours), .arm(arm), .set_en(set_en), .set_hours(set_hours),
        .set_minutes(set_minutes), .snooze(snooze), .stop(stop),
        .alarm_out(alarm_out), .armed(armed), .snoozing(snoozing),
        .set_err(set_err), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model: time as seconds-of-day, alarm/snooze as minute-of-day
    int tod = 0;
    int m_prev = 0;
    bit m_armed, m_ring, m_snz, m_err;
    int m_alarm_min = 0;
    int m_snz_min = 0;
    int m_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_ring = 0; m_snz = 0; m_err = 0;
        m_alarm_min = 0; m_snz_min = 0; m_left = 0; m_prev = 0;
    endtask

    task automatic model_update();
        bit new_ev;
        bit on_min;
        int cur_min;
        int new_alarm;
        new_ev    = (tod != m_prev);
        on_min    = new_ev && (tod % 60 == 0);
        cur_min   = tod / 60;
        new_alarm = m_alarm_min;
        m_err     = 0;
        if (set_en && !m_ring && !m_snz) begin
            if (set_hours <= 23 && set_minutes <= 59) new_alarm = int'(set_hours) * 60 + int'(set_minutes);
            else m_err = 1;
        end
        if (!arm) begin
            m_armed = 0; m_ring = 0; m_snz = 0;
        end else if (!m_armed) begin
            m_armed = 1;
        end else if (m_ring) begin
            if (stop) m_ring = 0;
            else if (snooze) begin
                m_ring = 0; m_snz = 1;
                m_snz_min = (cur_min + SNZ) % 1440;
            end else if (new_ev) begin
                m_left--;
                if (m_left == 0) m_ring = 0;
            end
        end else if (m_snz) begin
            if (stop) m_snz = 0;
            else if (on_min && cur_min == m_snz_min) begin
                m_snz = 0; m_ring = 1; m_left = LIM;
            end
        end else if (on_min && cur_min == m_alarm_min) begin
            m_ring = 1; m_left = LIM;
        end
        m_alarm_min = new_alarm;
        m_prev = tod;
    endtask

    // driver tasks
    task automatic set_time(input int t);
        tod     = t;
        hours   = 5'(t / 3600);
        minutes = 6'((t / 60) % 60);
        seconds = 6'(t % 60);
    endtask

    task automatic advance();
        set_time((tod + 1) % 86400);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else model_update();
        @(negedge clk);
    endtask

    task automatic load_alarm(input int h, input int m);
        set_en = 1; set_hours = 5'(h); set_minutes = 6'(m);
        tick();
        set_en = 0;
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        check("alarm_out", 32'(alarm_out), 32'(m_ring));
        check("armed", 32'(armed), 32'(m_armed));
        check("snoozing", 32'(snoozing), 32'(m_snz));
        check("set_err", 32'(set_err), 32'(m_err));
        check("alarm_hours", 32'(alarm_hours), 32'(m_alarm_min / 60));
        check("alarm_minutes", 32'(alarm_minutes), 32'(m_alarm_min % 60));
    end

    int r;

    initial begin
        model_reset();
        #12;
        check("rst_alarm_out", 32'(alarm_out), 0);
        check("rst_armed", 32'(armed), 0);
        check("rst_alarm_hours", 32'(alarm_hours), 0);
        arm = 1;
        @(negedge clk); #2 reset = 1;
        tick();
        check("arm_armed", 32'(armed), 1);

        // ring at 07:30, timeout after 60 events
        load_alarm(7, 30);
        check("load_h", 32'(alarm_hours), 7);
        check("load_m", 32'(alarm_minutes), 30);
        set_time(7 * 3600 + 29 * 60 + 59); tick();
        check("pre_match", 32'(alarm_out), 0);
        advance(); tick();
        check("match_ring", 32'(alarm_out), 1);
        check("match_armed", 32'(armed), 1);
        repeat (59) begin advance(); tick(); end
        check("ring_59", 32'(alarm_out), 1);
        advance(); tick();
        check("timeout", 32'(alarm_out), 0);
        check("timeout_armed", 32'(armed), 1);

        // held time never retriggers
        set_time(7 * 3600 + 30 * 60); tick();
        check("rering", 32'(alarm_out), 1);
        stop = 1; tick(); stop = 0;
        check("stop", 32'(alarm_out), 0);
        repeat (5) tick();
        check("hold_no_retrig", 32'(alarm_out), 0);

        // snooze across midnight
        load_alarm(23, 58);
        set_time(23 * 3600 + 57 * 60 + 59); tick();
        advance(); tick();
        check("ring_2358", 32'(alarm_out), 1);
        snooze = 1; tick(); snooze = 0;
        check("snz_on", 32'(snoozing), 1);
        check("snz_quiet", 32'(alarm_out), 0);
        set_time(2 * 60 + 59); tick();
        check("snz_wait", 32'(snoozing), 1);
        advance(); tick();
        check("snz_ring", 32'(alarm_out), 1);
        check("snz_off", 32'(snoozing), 0);

        // stop beats snooze
        stop = 1; snooze = 1; tick(); stop = 0; snooze = 0;
        check("ss_alarm", 32'(alarm_out), 0);
        check("ss_snz", 32'(snoozing), 0);
        check("ss_armed", 32'(armed), 1);

        // rejected sets
        load_alarm(7, 30);
        check("set_ok_err", 32'(set_err), 0);
        load_alarm(24, 10);
        check("err_h", 32'(set_err), 1);
        tick();
        check("err_pulse", 32'(set_err), 0);
        load_alarm(12, 60);
        check("err_m", 32'(set_err), 1);
        check("keep_h", 32'(alarm_hours), 7);
        check("keep_m", 32'(alarm_minutes), 30);
        set_time(7 * 3600 + 29 * 60 + 59); tick();
        advance(); tick();
        load_alarm(8, 0);
        check("ring_set_ign", 32'(alarm_hours), 7);
        check("ring_set_noerr", 32'(set_err), 0);
        check("ring_still", 32'(alarm_out), 1);

        // async reset mid-ring
        @(negedge clk); #2 reset = 0;
        #1;
        model_reset();
        check("arst_alarm", 32'(alarm_out), 0);
        check("arst_armed", 32'(armed), 0);
        check("arst_ah", 32'(alarm_hours), 0);
        check("arst_am", 32'(alarm_minutes), 0);
        @(negedge clk); #2 reset = 1;
        tick();
        check("rel_armed", 32'(armed), 1);
        check("rel_alarm", 32'(alarm_hours), 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) set_time((m_alarm_min * 60 - int'($urandom_range(1, 3)) + 86400) % 86400);
            else if (r < 6 && m_snz) set_time((m_snz_min * 60 - 1 + 86400) % 86400);
            else if (r >= 12) advance();
            arm         = ($urandom_range(0, 99) < 97);
            stop        = ($urandom_range(0, 99) < 2);
            snooze      = ($urandom_range(0, 99) < 3);
            set_en      = ($urandom_range(0, 99) < 3);
            set_hours   = 5'($urandom_range(0, 25));
            set_minutes = 6'($urandom_range(0, 62));
            tick();
        end
        set_en = 0; stop = 0; snooze = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
